// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_conflict_monitor
// Purpose  : Safety monitor placed between an intersection controller and the
//            field lamps. It samples both roads' {R,Y,G} drives every cycle
//            and checks them for:
//              - bad encoding
//              - conflicts
//              - illegal transitions
//              - short yellow
//              - over-long dwell
//            On a violation it latches the cause and flashes both roads red
//            until an operator clears the fault.
// Ports    : clk         - system clock, rising edge
//            reset       - synchronous reset, active low
//            light_main  - main-road lamp drive {R,Y,G}
//            light_side  - side-road lamp drive {R,Y,G}
//            fault_clear - one-cycle operator request to leave fault mode
//            safe_main   - main-road lamp drive to field
//            safe_side   - side-road lamp drive to field
//            fault       - high while in fault mode
//            fault_code  - latched fault cause (0 none, 1..5)
//            fault_cnt   - saturating count of fault entries since reset
// Revision : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor #(
  parameter logic [31:0] MIN_YELLOW = 32'd150000000,
  parameter logic [31:0] MAX_PHASE  = 32'd3600000000,
  parameter logic [31:0] FLASH_HALF = 32'd25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_main,
  input  logic [2:0] light_side,
  input  logic       fault_clear,
  output logic [2:0] safe_main,
  output logic [2:0] safe_side,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam logic [2:0]  LAMP_R    = 3'b100;
  localparam logic [2:0]  LAMP_Y    = 3'b010;
  localparam logic [2:0]  LAMP_G    = 3'b001;
  localparam logic [2:0]  LAMP_OFF  = 3'b000;
  localparam logic [31:0] DWELL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_ARMING  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  main_s_q, main_s_d, side_s_q, side_s_d;
  logic [2:0]  main_p_q, main_p_d, side_p_q, side_p_d;
  logic [31:0] main_dwell_q, main_dwell_d, side_dwell_q, side_dwell_d;
  logic        main_ylw_short_q, main_ylw_short_d;
  logic        side_ylw_short_q, side_ylw_short_d;
  logic [31:0] flash_cnt_q, flash_cnt_d;
  logic        flash_off_q, flash_off_d;
  logic [2:0]  fault_code_q, fault_code_d;
  logic [7:0]  fault_cnt_q, fault_cnt_d;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
  endfunction

  function automatic logic step_ok(input logic [2:0] prv, input logic [2:0] cur);
    return (prv == cur) ||
           ((prv == LAMP_G) && (cur == LAMP_Y)) ||
           ((prv == LAMP_Y) && (cur == LAMP_R)) ||
           ((prv == LAMP_R) && (cur == LAMP_G));
  endfunction

  logic       enc_bad, conflict, trans_bad, ylw_bad, dwell_bad;
  logic [2:0] viol_code;
  logic       leave_fault;

  assign enc_bad   = !is_onehot(main_s_q) || !is_onehot(side_s_q);
  assign conflict  = (main_s_q != LAMP_R) && (side_s_q != LAMP_R);
  assign trans_bad = !step_ok(main_p_q, main_s_q) || !step_ok(side_p_q, side_s_q);
  // The short-yellow flags describe the yellow run that has just ended, so
  // they are only meaningful together with a Y->R change on that road.
  assign ylw_bad   = ((main_p_q == LAMP_Y) && (main_s_q == LAMP_R) && main_ylw_short_q) ||
                     ((side_p_q == LAMP_Y) && (side_s_q == LAMP_R) && side_ylw_short_q);
  assign dwell_bad = (main_dwell_q >= MAX_PHASE) || (side_dwell_q >= MAX_PHASE);

  // Lowest-numbered active code; transition, yellow and dwell checks apply
  // only once armed.
  always_comb begin
    viol_code = 3'd0;
    if (enc_bad) begin
      viol_code = 3'd1;
    end else if (conflict) begin
      viol_code = 3'd2;
    end else if (state_q == ST_MONITOR) begin
      if (trans_bad)      viol_code = 3'd3;
      else if (ylw_bad)   viol_code = 3'd4;
      else if (dwell_bad) viol_code = 3'd5;
    end
  end

  // Next-state, fault bookkeeping and flash timing
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    fault_cnt_d  = fault_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    flash_off_d  = flash_off_q;
    leave_fault  = 1'b0;
    case (state_q)
      ST_ARMING, ST_MONITOR: begin
        if (viol_code != 3'd0) begin
          state_d      = ST_FAULT;
          fault_code_d = viol_code;
          fault_cnt_d  = (fault_cnt_q == 8'hFF) ? 8'hFF : fault_cnt_q + 8'd1;
          flash_cnt_d  = 32'd0;
          flash_off_d  = 1'b0;
        end else begin
          state_d = ST_MONITOR;
        end
      end
      ST_FAULT: begin
        // viol_code only reflects codes 1/2 here, so zero means clearable.
        if (fault_clear && (viol_code == 3'd0)) begin
          state_d      = ST_ARMING;
          fault_code_d = 3'd0;
          leave_fault  = 1'b1;
        end else if (flash_cnt_q >= FLASH_HALF - 32'd1) begin
          flash_cnt_d = 32'd0;
          flash_off_d = !flash_off_q;
        end else begin
          flash_cnt_d = flash_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_ARMING;
    endcase
  end

  // Sampling, previous copies and dwell tracking
  always_comb begin
    main_s_d         = light_main;
    side_s_d         = light_side;
    main_p_d         = main_s_q;
    side_p_d         = side_s_q;
    main_ylw_short_d = (main_s_q == LAMP_Y) && (main_dwell_q < MIN_YELLOW);
    side_ylw_short_d = (side_s_q == LAMP_Y) && (side_dwell_q < MIN_YELLOW);
    if (leave_fault || (light_main != main_s_q)) main_dwell_d = 32'd1;
    else if (main_dwell_q == DWELL_MAX)          main_dwell_d = DWELL_MAX;
    else                                         main_dwell_d = main_dwell_q + 32'd1;
    if (leave_fault || (light_side != side_s_q)) side_dwell_d = 32'd1;
    else if (side_dwell_q == DWELL_MAX)          side_dwell_d = DWELL_MAX;
    else                                         side_dwell_d = side_dwell_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_ARMING;
      main_s_q         <= LAMP_R;
      side_s_q         <= LAMP_R;
      main_p_q         <= LAMP_R;
      side_p_q         <= LAMP_R;
      main_dwell_q     <= 32'd0;
      side_dwell_q     <= 32'd0;
      main_ylw_short_q <= 1'b0;
      side_ylw_short_q <= 1'b0;
      flash_cnt_q      <= 32'd0;
      flash_off_q      <= 1'b0;
      fault_code_q     <= 3'd0;
      fault_cnt_q      <= 8'd0;
    end else begin
      state_q          <= state_d;
      main_s_q         <= main_s_d;
      side_s_q         <= side_s_d;
      main_p_q         <= main_p_d;
      side_p_q         <= side_p_d;
      main_dwell_q     <= main_dwell_d;
      side_dwell_q     <= side_dwell_d;
      main_ylw_short_q <= main_ylw_short_d;
      side_ylw_short_q <= side_ylw_short_d;
      flash_cnt_q      <= flash_cnt_d;
      flash_off_q      <= flash_off_d;
      fault_code_q     <= fault_code_d;
      fault_cnt_q      <= fault_cnt_d;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign safe_main  = fault ? (flash_off_q ? LAMP_OFF : LAMP_R) : main_s_q;
  assign safe_side  = fault ? (flash_off_q ? LAMP_OFF : LAMP_R) : side_s_q;
  assign fault_code = fault_code_q;
  assign fault_cnt  = fault_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_conflict_monitor
// Purpose  : Self-checking bench for traffic_conflict_monitor with short
//            timing parameters. Directed scenarios plus a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

  localparam int MINY  = 4;
  localparam int MAXP  = 20;
  localparam int FHALF = 3;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] light_main = R;
  logic [2:0] light_side = R;
  logic       fault_clear = 1'b0;
  logic [2:0] safe_main, safe_side, fault_code;
  logic       fault;
  logic [7:0] fault_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_conflict_monitor #(
    .MIN_YELLOW(32'd4),
    .MAX_PHASE (32'd20),
    .FLASH_HALF(32'd3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .light_main (light_main),
    .light_side (light_side),
    .fault_clear(fault_clear),
    .safe_main  (safe_main),
    .safe_side  (safe_side),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 arming, 1 monitoring, 2 fault
  int         m_mode = 0;
  bit         m_valid = 1'b0;
  logic [2:0] m_main = R, m_side = R, m_pmain = R, m_pside = R;
  longint     m_run_main = 0, m_run_side = 0;   // length of current sampled run
  longint     m_end_main = 0, m_end_side = 0;   // length of the run that just ended
  int         m_code = 0, m_cnt = 0, m_tf = 0;  // m_tf: cycles since fault entry

  function automatic bit onehot(input logic [2:0] v);
    return (v == R) || (v == Y) || (v == G);
  endfunction

  function automatic bit legal_change(input logic [2:0] a, input logic [2:0] b);
    return (a == b) || (a == G && b == Y) || (a == Y && b == R) || (a == R && b == G);
  endfunction

  initial forever begin
    int  c;
    bit  leave;
    @(posedge clk);
    if (!reset) begin
      m_valid = 1'b1;
      m_mode = 0; m_main = R; m_side = R; m_pmain = R; m_pside = R;
      m_run_main = 0; m_run_side = 0; m_end_main = 0; m_end_side = 0;
      m_code = 0; m_cnt = 0; m_tf = 0;
    end else begin
      c = 0;
      if (!onehot(m_main) || !onehot(m_side)) c = 1;
      else if (m_main != R && m_side != R) c = 2;
      else if (m_mode == 1) begin
        if (!legal_change(m_pmain, m_main) || !legal_change(m_pside, m_side)) c = 3;
        else if ((m_pmain == Y && m_main == R && m_end_main < MINY) ||
                 (m_pside == Y && m_side == R && m_end_side < MINY)) c = 4;
        else if (m_run_main >= MAXP || m_run_side >= MAXP) c = 5;
      end
      leave = 1'b0;
      if (m_mode == 2) begin
        if (fault_clear && c == 0) begin
          m_mode = 0; m_code = 0; leave = 1'b1;
        end else begin
          m_tf++;
        end
      end else if (c != 0) begin
        m_mode = 2; m_code = c; m_tf = 0;
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else begin
        m_mode = 1;
      end
      m_pmain = m_main;
      m_pside = m_side;
      if (light_main != m_main) begin m_end_main = m_run_main; m_run_main = 1; end
      else if (m_run_main < 64'hFFFF_FFFF) m_run_main++;
      if (light_side != m_side) begin m_end_side = m_run_side; m_run_side = 1; end
      else if (m_run_side < 64'hFFFF_FFFF) m_run_side++;
      m_main = light_main;
      m_side = light_side;
      if (leave) begin m_run_main = 1; m_run_side = 1; end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    logic [2:0] e_sm, e_ss;
    logic       e_f;
    @(negedge clk);
    if (m_valid) begin
      e_f  = (m_mode == 2);
      e_sm = e_f ? ((((m_tf / FHALF) % 2) == 0) ? R : 3'b000) : m_main;
      e_ss = e_f ? ((((m_tf / FHALF) % 2) == 0) ? R : 3'b000) : m_side;
      chk("model_safe_main",  32'(safe_main),  32'(e_sm));
      chk("model_safe_side",  32'(safe_side),  32'(e_ss));
      chk("model_fault",      32'(fault),      32'(e_f));
      chk("model_fault_code", 32'(fault_code), 32'(m_code));
      chk("model_fault_cnt",  32'(fault_cnt),  32'(m_cnt));
    end
  end

  // Drive lamps (fault_clear only on the first cycle), wait n negedges.
  task automatic step(input logic [2:0] m, input logic [2:0] s, input logic clr, input int n);
    light_main  = m;
    light_side  = s;
    fault_clear = clr;
    @(negedge clk);
    fault_clear = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [2:0] flash_exp [7];
    flash_exp = '{R, R, R, 3'b000, 3'b000, 3'b000, R};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_safe_main", 32'(safe_main), 32'h4);
    chk("rst_safe_side", 32'(safe_side), 32'h4);
    chk("rst_fault",     32'(fault),     32'h0);
    chk("rst_code",      32'(fault_code), 32'h0);
    chk("rst_cnt",       32'(fault_cnt),  32'h0);
    reset = 1'b1;

    // Legal cycle twice; a stray fault_clear outside fault is ignored
    for (int r = 0; r < 2; r++) begin
      step(G, R, (r == 1), 10);
      chk("norm_safe_main_g", 32'(safe_main), 32'h1);
      chk("norm_safe_side_r", 32'(safe_side), 32'h4);
      step(Y, R, 0, 4);
      step(R, G, 0, 10);
      step(R, Y, 0, 4);
    end
    chk("norm_fault", 32'(fault), 32'h0);

    // Conflict: both green
    step(G, G, 0, 1);
    chk("conf_not_yet", 32'(fault), 32'h0);
    step(G, G, 0, 1);
    chk("conf_fault", 32'(fault), 32'h1);
    chk("conf_code",  32'(fault_code), 32'h2);
    chk("conf_cnt",   32'(fault_cnt), 32'h1);
    for (int i = 0; i < 7; i++) begin
      chk("flash_main", 32'(safe_main), 32'(flash_exp[i]));
      chk("flash_side", 32'(safe_side), 32'(flash_exp[i]));
      step(G, G, 0, 1);
    end
    chk("code_held", 32'(fault_code), 32'h2);

    // Clear refused while samples conflict, accepted with both red
    step(G, G, 1, 1);
    chk("clr_refused", 32'(fault), 32'h1);
    step(R, R, 0, 1);
    step(R, R, 1, 1);
    chk("clr_fault", 32'(fault), 32'h0);
    chk("clr_code",  32'(fault_code), 32'h0);
    chk("clr_cnt",   32'(fault_cnt), 32'h1);
    chk("clr_safe",  32'(safe_main), 32'h4);
    step(R, R, 0, 2);

    // Bad encoding
    step(3'b011, R, 0, 2);
    chk("enc_code", 32'(fault_code), 32'h1);
    chk("enc_cnt",  32'(fault_cnt), 32'h2);
    step(R, R, 0, 1);
    step(R, R, 1, 1);
    step(R, R, 0, 1);

    // Short yellow
    step(G, R, 0, 3);
    step(Y, R, 0, 2);
    step(R, R, 0, 2);
    chk("ylw_code", 32'(fault_code), 32'h4);
    chk("ylw_cnt",  32'(fault_cnt), 32'h3);
    step(R, R, 1, 1);
    chk("ylw_clr", 32'(fault), 32'h0);
    step(R, R, 0, 1);

    // Illegal G->R
    step(G, R, 0, 3);
    step(R, R, 0, 2);
    chk("trans_code", 32'(fault_code), 32'h3);
    chk("trans_cnt",  32'(fault_cnt), 32'h4);
    step(R, R, 1, 1);
    chk("trans_clr", 32'(fault), 32'h0);

    // Dwell limit
    step(R, R, 0, 15);
    chk("dwell_early", 32'(fault), 32'h0);
    step(R, R, 0, 10);
    chk("dwell_fault", 32'(fault), 32'h1);
    chk("dwell_code",  32'(fault_code), 32'h5);
    chk("dwell_cnt",   32'(fault_cnt), 32'h5);

    // Reset during flash-off
    for (int i = 0; i < 10 && safe_main !== 3'b000; i++) @(negedge clk);
    chk("flash_off_reached", 32'(safe_main), 32'h0);
    reset = 1'b0;
    step(R, R, 0, 1);
    chk("mid_rst_safe_main", 32'(safe_main), 32'h4);
    chk("mid_rst_safe_side", 32'(safe_side), 32'h4);
    chk("mid_rst_fault",     32'(fault), 32'h0);
    chk("mid_rst_cnt",       32'(fault_cnt), 32'h0);
    reset = 1'b1;
    step(G, R, 0, 3);
    step(Y, R, 0, 4);
    step(R, G, 0, 3);
    chk("post_rst_fault", 32'(fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_bad++;
    $display("FAIL timeout: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
